// File: rtl/rsa_pkg.sv
// Shared types for the RSA box: FSM state encoding and modmul operand selection.
package rsa_pkg;

  localparam int RSA_WIDTH = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_TEST,
    ST_MUL,
    ST_SQR,
    ST_FINISH
  } mexp_state_t;

  typedef enum logic [1:0] {
    OP_REDUCE,
    OP_MUL,
    OP_SQR
  } mm_op_t;

endpackage

// File: rtl/mod_exp_engine_mod_mult.sv
// Bit-serial interleaved modular multiplier: o_res = i_a * i_b mod i_m, MSB of a first.
module mod_mult #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_m,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_a, r_b, r_m, r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH+1:0] w_m, w_sum, w_s1, w_s2;

  // r < m and b < m bound 2r + b below 3m, so two trial subtractions always suffice
  always_comb begin
    w_m   = {2'b00, r_m};
    w_sum = {1'b0, r_r, 1'b0} + (r_a[WIDTH-1] ? {2'b00, r_b} : '0);
    w_s1  = (w_sum >= w_m) ? w_sum - w_m : w_sum;
    w_s2  = (w_s1 >= w_m) ? w_s1 - w_m : w_s1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_m   <= i_m;
        r_r   <= '0;
        r_cnt <= CW'(WIDTH);
      end else if (r_cnt != '0) begin
        r_r   <= w_s2[WIDTH-1:0];
        r_a   <= r_a << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) r_done <= 1'b1;
      end
    end
  end

  assign o_done = r_done;
  assign o_res  = r_r;

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation over one shared mod_mult.
module mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  mexp_state_t      r_state;
  logic             r_go, r_busy, r_done, r_error;
  logic [WIDTH-1:0] r_base, r_exp, r_mod, r_acc, r_b, r_result;

  mm_op_t           w_op;
  logic [WIDTH-1:0] w_mm_a, w_mm_b, w_mm_res, w_e_sh, w_tst_exp;
  logic             w_mm_start, w_mm_done, w_special;
  mexp_state_t      w_tst_state;

  assign w_special  = (r_mod <= WIDTH'(1)) || (r_exp == '0);
  assign w_mm_start = r_go && !(r_state == ST_REDUCE && w_special);
  assign w_e_sh     = r_exp >> 1;

  always_comb begin
    unique case (r_state)
      ST_MUL:  w_op = OP_MUL;
      ST_SQR:  w_op = OP_SQR;
      default: w_op = OP_REDUCE;
    endcase
    unique case (w_op)
      OP_MUL:  begin w_mm_a = r_acc;  w_mm_b = r_b;        end
      OP_SQR:  begin w_mm_a = r_b;    w_mm_b = r_b;        end
      default: begin w_mm_a = r_base; w_mm_b = WIDTH'(1);  end
    endcase
  end

  // TEST is resolved combinationally in the cycle a REDUCE or SQR completes,
  // so every modmul costs exactly its own cycles and no extra decision cycle.
  always_comb begin
    if (r_exp[0]) begin
      w_tst_state = ST_MUL;
      w_tst_exp   = r_exp;
    end else begin
      w_tst_state = (w_e_sh == '0) ? ST_FINISH : ST_SQR;
      w_tst_exp   = w_e_sh;
    end
  end

  mod_mult #(.WIDTH(WIDTH)) u_mm (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_mm_start),
    .i_a     (w_mm_a),
    .i_b     (w_mm_b),
    .i_m     (r_mod),
    .o_done  (w_mm_done),
    .o_res   (w_mm_res)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_go     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_base   <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      r_go   <= 1'b0;
      if (r_done) r_busy <= 1'b0;
      case (r_state)
        ST_IDLE: if (start && !r_busy) begin
          r_base  <= base;
          r_exp   <= exponent;
          r_mod   <= modulus;
          r_busy  <= 1'b1;
          r_go    <= 1'b1;
          r_state <= ST_REDUCE;
        end
        ST_REDUCE: begin
          if (r_go && w_special) begin
            r_done   <= 1'b1;
            r_error  <= (r_mod == '0);
            r_result <= (r_mod <= WIDTH'(1)) ? '0 : WIDTH'(1);
            r_state  <= ST_IDLE;
          end else if (w_mm_done) begin
            r_b     <= w_mm_res;
            r_acc   <= WIDTH'(1);
            r_exp   <= w_tst_exp;
            r_state <= w_tst_state;
            r_go    <= (w_tst_state != ST_FINISH);
          end
        end
        ST_SQR: if (w_mm_done) begin
          r_b     <= w_mm_res;
          r_exp   <= w_tst_exp;
          r_state <= w_tst_state;
          r_go    <= (w_tst_state != ST_FINISH);
        end
        ST_MUL: if (w_mm_done) begin
          r_acc   <= w_mm_res;
          r_exp   <= w_e_sh;
          r_state <= (w_e_sh == '0) ? ST_FINISH : ST_SQR;
          r_go    <= (w_e_sh != '0);
        end
        ST_FINISH: begin
          r_done   <= 1'b1;
          r_error  <= 1'b0;
          r_result <= r_acc;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign error  = r_error;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Random and directed checks of mod_exp_engine at WIDTH 16 and 128 against a plain-arithmetic model.
module tb_mod_exp_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         s16, bz16, d16, er16;
  logic [15:0]  b16, e16, m16, r16;
  logic         s128, bz128, d128, er128;
  logic [127:0] b128, e128, m128, r128;

  int nvec = 0;
  int nerr = 0;

  mod_exp_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(s16), .base(b16), .exponent(e16), .modulus(m16),
    .busy(bz16), .done(d16), .result(r16), .error(er16));

  mod_exp_engine #(.WIDTH(128)) dut128 (
    .clk(clk), .reset(reset), .start(s128), .base(b128), .exponent(e128), .modulus(m128),
    .busy(bz128), .done(d128), .result(r128), .error(er128));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_exp(input logic [127:0] b, e, m);
    logic [255:0] r, bb;
    if (m == 0) return '0;
    r  = 256'(1) % m;
    bb = b % m;
    for (int i = 127; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * bb) % m;
    end
    return r[127:0];
  endfunction

  function automatic int ref_cyc(input logic [127:0] e, m, input int w);
    int l, k;
    if (m <= 1 || e == 0) return 2;
    l = 0; k = 0;
    for (int i = 0; i < 128; i++) if (e[i]) begin k++; l = i + 1; end
    return 2 + (l + k) * (w + 2);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drv(input bit wide, input logic [127:0] b, e, m, input logic s);
    if (wide) begin b128 = b; e128 = e; m128 = m; s128 = s; end
    else begin b16 = b[15:0]; e16 = e[15:0]; m16 = m[15:0]; s16 = s; end
  endtask

  task automatic run(input bit wide, input logic [127:0] b_in, e_in, m_in,
                     input int poke, input string tag);
    logic [127:0] b, e, m, xr;
    int xc, cyc;
    logic dn;
    b = b_in; e = e_in; m = m_in;
    if (!wide) begin b &= 128'hFFFF; e &= 128'hFFFF; m &= 128'hFFFF; end
    xr = ref_exp(b, e, m);
    xc = ref_cyc(e, m, wide ? 128 : 16);
    @(posedge clk); #1;
    drv(wide, b, e, m, 1'b1);
    @(posedge clk); #1;
    cyc = 1;
    // scramble inputs: the engine must work from its sampled copies
    drv(wide, rnd128(), rnd128(), rnd128(), 1'b0);
    chk({tag, "_busy1"}, wide ? bz128 : bz16, 1);
    dn = wide ? d128 : d16;
    while (!dn && cyc < xc + 40) begin
      if (wide) s128 = (cyc == poke); else s16 = (cyc == poke);
      @(posedge clk); #1;
      cyc++;
      dn = wide ? d128 : d16;
    end
    if (wide) s128 = 1'b0; else s16 = 1'b0;
    chk({tag, "_done"}, dn, 1);
    chk({tag, "_lat"}, cyc, xc);
    chk({tag, "_res"}, wide ? r128 : {112'b0, r16}, xr);
    chk({tag, "_err"}, wide ? er128 : er16, (m == 0));
    chk({tag, "_busyd"}, wide ? bz128 : bz16, 1);
    @(posedge clk); #1;
    chk({tag, "_busy0"}, wide ? bz128 : bz16, 0);
    chk({tag, "_done0"}, wide ? d128 : d16, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold"}, wide ? r128 : {112'b0, r16}, xr);
  endtask

  initial begin
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst16", {bz16, d16, er16, r16}, 0);
    chk("rst128", {bz128, d128, er128} | (r128 != 0), 0);
    reset = 1'b1;

    run(0, 4, 13, 497, -1, "w16_4_13");
    run(0, 1000, 1, 497, -1, "w16_reduce");
    run(0, 77, 0, 497, -1, "w16_e0");
    run(0, 77, 5, 1, -1, "w16_m1");
    run(0, 77, 5, 0, -1, "w16_m0");
    run(0, 77, 0, 0, -1, "w16_m0e0");
    run(0, 4, 13, 497, 20, "w16_poke");
    for (int i = 0; i < 25; i++)
      run(0, {96'b0, $urandom()}, {112'b0, 16'($urandom())}, {112'b0, 16'($urandom())}, -1, "w16_rnd");

    run(1, 65, 17, 3233, -1, "rsa_enc");
    run(1, 2790, 2753, 3233, -1, "rsa_dec");
    run(1, 2, 128, {128{1'b1}}, -1, "w128_full");
    run(1, 2790, 2753, 3233, 300, "w128_poke");
    for (int i = 0; i < 4; i++)
      run(1, rnd128(), {112'b0, 16'($urandom())}, rnd128(), -1, "w128_rnd");

    // abort a long operation with reset at cycle 50
    @(posedge clk); #1;
    drv(1, 2790, 2753, 3233, 1'b1);
    @(posedge clk); #1;
    s128 = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    chk("pre_rst_busy", bz128, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_busy", bz128, 0);
    chk("abort_done", d128, 0);
    chk("abort_res", r128, 0);
    chk("abort_err", er128, 0);
    run(1, 65, 17, 3233, -1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
